// File: rtl/vga_game_pkg.sv
// ============================================================================
// Module  : vga_game_pkg
// Brief   : Shared FSM state encoding and pixel colour constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_game_pkg;

   localparam int c_COORD_W = 10;

   typedef enum logic [0:0] {
      MANUAL = 1'b0,
      BOUNCE = 1'b1
   } game_state_t;

   typedef struct packed {
      logic [2:0] red;
      logic [2:0] green;
      logic [1:0] blue;
   } rgb_t;

   localparam rgb_t c_RGB_BLACK  = '{red: 3'd0, green: 3'd0, blue: 2'd0};
   localparam rgb_t c_RGB_BORDER = '{red: 3'd7, green: 3'd7, blue: 2'd3};
   localparam rgb_t c_RGB_SPRITE = '{red: 3'd0, green: 3'd7, blue: 2'd0};
   localparam rgb_t c_RGB_FLASH  = '{red: 3'd7, green: 3'd0, blue: 2'd0};

endpackage

`default_nettype wire

// File: rtl/axis_mover.sv
// ============================================================================
// Module  : axis_mover
// Brief   : One sprite axis: position, direction, clamp and reflect logic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_mover
   import vga_game_pkg::*;
#(
   parameter int LO   = 10,
   parameter int HI   = 600,
   parameter int INIT = 320
)(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 tick,
   input  logic                 bounce,
   input  logic                 dec,
   input  logic                 inc,
   output logic [c_COORD_W-1:0] pos,
   output logic                 dir_neg,
   output logic                 reflect
);

   localparam logic [c_COORD_W-1:0] c_LO   = c_COORD_W'(LO);
   localparam logic [c_COORD_W-1:0] c_HI   = c_COORD_W'(HI);
   localparam logic [c_COORD_W-1:0] c_INIT = c_COORD_W'(INIT);

   logic [c_COORD_W-1:0] r_pos;
   logic [c_COORD_W-1:0] w_pos_next;
   logic                 r_dir_neg;
   logic                 w_dir_next;
   logic                 w_reflect;
   logic                 w_at_hi;
   logic                 w_at_lo;

   assign w_at_hi = (r_pos >= c_HI);
   assign w_at_lo = (r_pos <= c_LO);

   always_comb begin
      w_pos_next = r_pos;
      w_dir_next = r_dir_neg;
      w_reflect  = 1'b0;
      if (bounce) begin
         // A step that would leave the range holds the limit and turns around.
         if (!r_dir_neg) begin
            if (w_at_hi) begin
               w_pos_next = c_HI;
               w_dir_next = 1'b1;
               w_reflect  = 1'b1;
            end else begin
               w_pos_next = r_pos + 1'b1;
            end
         end else begin
            if (w_at_lo) begin
               w_pos_next = c_LO;
               w_dir_next = 1'b0;
               w_reflect  = 1'b1;
            end else begin
               w_pos_next = r_pos - 1'b1;
            end
         end
      end else if (inc && !dec) begin
         w_pos_next = w_at_hi ? c_HI : r_pos + 1'b1;
      end else if (dec && !inc) begin
         w_pos_next = w_at_lo ? c_LO : r_pos - 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pos     <= c_INIT;
         r_dir_neg <= 1'b0;
      end else if (tick) begin
         r_pos     <= w_pos_next;
         r_dir_neg <= w_dir_next;
      end
   end

   assign pos     = r_pos;
   assign dir_neg = r_dir_neg;
   assign reflect = tick & w_reflect;

endmodule

`default_nettype wire

// File: rtl/vga_sprite_game.sv
// ============================================================================
// Module  : vga_sprite_game
// Brief   : Switch- or bounce-driven square sprite with border and hit flash.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sprite_game
   import vga_game_pkg::*;
#(
   parameter int H_RES         = 640,
   parameter int V_RES         = 480,
   parameter int SIZE          = 30,
   parameter int BORDER        = 10,
   parameter int PRESCALE_BITS = 16,
   parameter int INIT_X        = 320,
   parameter int INIT_Y        = 240,
   parameter int FLASH_TICKS   = 8
)(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [c_COORD_W-1:0] x,
   input  logic [c_COORD_W-1:0] y,
   input  logic                 blank,
   input  logic                 up_switch,
   input  logic                 dn_switch,
   input  logic                 left_switch,
   input  logic                 right_switch,
   input  logic                 mode_switch,
   output logic [2:0]           RED,
   output logic [2:0]           GREEN,
   output logic [1:0]           BLUE,
   output logic                 hit
);

   localparam int c_NUM_SW  = 5;
   localparam int c_FLASH_W = $clog2(FLASH_TICKS + 1);

   localparam logic [c_COORD_W-1:0] c_X_BORDER_LO = c_COORD_W'(BORDER);
   localparam logic [c_COORD_W-1:0] c_X_BORDER_HI = c_COORD_W'(H_RES - BORDER);
   localparam logic [c_COORD_W-1:0] c_Y_BORDER_LO = c_COORD_W'(BORDER);
   localparam logic [c_COORD_W-1:0] c_Y_BORDER_HI = c_COORD_W'(V_RES - BORDER);
   localparam logic [c_COORD_W:0]   c_SIZE_EXT    = (c_COORD_W + 1)'(SIZE);

   // Switch synchronisers; index order is {mode, right, left, dn, up}
   logic [c_NUM_SW-1:0] w_sw_raw;
   logic [c_NUM_SW-1:0] r_sync_meta;
   logic [c_NUM_SW-1:0] r_sync;

   assign w_sw_raw = {mode_switch, right_switch, left_switch, dn_switch, up_switch};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sync_meta <= '1;
         r_sync      <= '1;
      end else begin
         r_sync_meta <= w_sw_raw;
         r_sync      <= r_sync_meta;
      end
   end

   logic w_up;
   logic w_dn;
   logic w_left;
   logic w_right;
   logic w_mode_bounce;

   assign w_up          = ~r_sync[0];
   assign w_dn          = ~r_sync[1];
   assign w_left        = ~r_sync[2];
   assign w_right       = ~r_sync[3];
   assign w_mode_bounce = ~r_sync[4];

   logic [PRESCALE_BITS-1:0] r_prescale;
   logic                     w_tick;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_prescale <= '0;
      end else begin
         r_prescale <= r_prescale + 1'b1;
      end
   end

   assign w_tick = &r_prescale;

   game_state_t r_state;
   game_state_t w_state_next;
   logic        w_bounce;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= MANUAL;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_tick) begin
         w_state_next = w_mode_bounce ? BOUNCE : MANUAL;
      end
   end

   // Movers use the incoming state so a mode change applies on its own tick.
   assign w_bounce = (w_state_next == BOUNCE);

   logic [c_COORD_W-1:0] o_x;
   logic [c_COORD_W-1:0] o_y;
   logic                 w_dx_neg;
   logic                 w_dy_neg;
   logic                 w_refl_x;
   logic                 w_refl_y;

   axis_mover #(
      .LO   (BORDER),
      .HI   (H_RES - BORDER - SIZE),
      .INIT (INIT_X)
   ) u_x (
      .CLK     (CLK),
      .RST     (RST),
      .tick    (w_tick),
      .bounce  (w_bounce),
      .dec     (w_left),
      .inc     (w_right),
      .pos     (o_x),
      .dir_neg (w_dx_neg),
      .reflect (w_refl_x)
   );

   axis_mover #(
      .LO   (BORDER),
      .HI   (V_RES - BORDER - SIZE),
      .INIT (INIT_Y)
   ) u_y (
      .CLK     (CLK),
      .RST     (RST),
      .tick    (w_tick),
      .bounce  (w_bounce),
      .dec     (w_up),
      .inc     (w_dn),
      .pos     (o_y),
      .dir_neg (w_dy_neg),
      .reflect (w_refl_y)
   );

   assign hit = w_refl_x | w_refl_y;

   logic [c_FLASH_W-1:0] r_flash;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_flash <= '0;
      end else if (hit) begin
         r_flash <= c_FLASH_W'(FLASH_TICKS);
      end else if (w_tick && (r_flash != '0)) begin
         r_flash <= r_flash - 1'b1;
      end
   end

   logic w_border;
   logic w_object;
   rgb_t w_rgb;

   assign w_border = (x < c_X_BORDER_LO) || (x >= c_X_BORDER_HI) ||
                     (y < c_Y_BORDER_LO) || (y >= c_Y_BORDER_HI);

   assign w_object = ({1'b0, x} >= {1'b0, o_x}) &&
                     ({1'b0, x} <  ({1'b0, o_x} + c_SIZE_EXT)) &&
                     ({1'b0, y} >= {1'b0, o_y}) &&
                     ({1'b0, y} <  ({1'b0, o_y} + c_SIZE_EXT));

   always_comb begin
      w_rgb = c_RGB_BLACK;
      if (blank) begin
         w_rgb = c_RGB_BLACK;
      end else if (w_border) begin
         w_rgb = c_RGB_BORDER;
      end else if (w_object) begin
         w_rgb = (r_flash != '0) ? c_RGB_FLASH : c_RGB_SPRITE;
      end
   end

   assign RED   = w_rgb.red;
   assign GREEN = w_rgb.green;
   assign BLUE  = w_rgb.blue;

endmodule

`default_nettype wire

// File: tb/tb_vga_sprite_game.sv
// ============================================================================
// Module  : tb_vga_sprite_game
// Brief   : Directed scoreboard bench for vga_sprite_game (16-cycle ticks).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sprite_game;
   import vga_game_pkg::*;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic       blank = 1'b0;
   logic       up_switch = 1'b1;
   logic       dn_switch = 1'b1;
   logic       left_switch = 1'b1;
   logic       right_switch = 1'b1;
   logic       mode_switch = 1'b1;
   logic [2:0] RED;
   logic [2:0] GREEN;
   logic [1:0] BLUE;
   logic       hit;

   vga_sprite_game #(
      .PRESCALE_BITS (4)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .x            (x),
      .y            (y),
      .blank        (blank),
      .up_switch    (up_switch),
      .dn_switch    (dn_switch),
      .left_switch  (left_switch),
      .right_switch (right_switch),
      .mode_switch  (mode_switch),
      .RED          (RED),
      .GREEN        (GREEN),
      .BLUE         (BLUE),
      .hit          (hit)
   );

   always #5 CLK = ~CLK;

   localparam logic [7:0] c_GREEN  = 8'h1C;
   localparam logic [7:0] c_RED    = 8'hE0;
   localparam logic [7:0] c_BORDER = 8'hFF;

   int          n_cmp  = 0;
   int          n_fail = 0;
   string       tag_q[$];
   logic [31:0] exp_q[$];

   int mx;
   int my;
   int mflash;
   bit mdxn;
   bit mdyn;

   task automatic expect_val(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic compare(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%0d", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
         end
      end
   endtask

   task automatic pixel(input int px, input int py, input logic pb, output logic [7:0] c);
      x     = 10'(px);
      y     = 10'(py);
      blank = pb;
      #1;
      c     = {RED, GREEN, BLUE};
      blank = 1'b0;
   endtask

   // Entered just after an update edge (prescaler 0); leaves 1 unit after the next one.
   task automatic do_tick(output logic h);
      repeat (15) @(posedge CLK);
      @(negedge CLK);
      h = hit;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST          = 1'b1;
      up_switch    = 1'b1;
      dn_switch    = 1'b1;
      left_switch  = 1'b1;
      right_switch = 1'b1;
      mode_switch  = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic model_tick(output logic h);
      h = 1'b0;
      if (!mdxn) begin
         if (mx >= 600) begin mdxn = 1'b1; h = 1'b1; end else mx++;
      end else begin
         if (mx <= 10) begin mdxn = 1'b0; h = 1'b1; end else mx--;
      end
      if (!mdyn) begin
         if (my >= 440) begin mdyn = 1'b1; h = 1'b1; end else my++;
      end else begin
         if (my <= 10) begin mdyn = 1'b0; h = 1'b1; end else my--;
      end
      if (h) mflash = 8;
      else if (mflash > 0) mflash--;
   endtask

   task automatic bounce_tick();
      logic       mh;
      logic       h;
      logic [7:0] c;
      model_tick(mh);
      expect_val("bounce_hit", 32'(mh));
      expect_val("bounce_x", mx);
      expect_val("bounce_y", my);
      expect_val("bounce_rgb", (mflash != 0) ? 32'(c_RED) : 32'(c_GREEN));
      do_tick(h);
      compare(32'(h));
      compare(32'(dut.o_x));
      compare(32'(dut.o_y));
      pixel(mx, my, 1'b0, c);
      compare(32'(c));
   endtask

   initial begin
      logic       h;
      logic [7:0] c;

      do_reset();

      // Reset state and pixel priorities around the sprite and borders
      expect_val("rst_x", 320);             compare(32'(dut.o_x));
      expect_val("rst_y", 240);             compare(32'(dut.o_y));
      expect_val("rst_state", 32'(MANUAL)); compare(32'(dut.r_state));
      expect_val("rst_hit", 0);             compare(32'(hit));
      expect_val("px_sprite", 32'(c_GREEN));
      pixel(320, 240, 1'b0, c); compare(32'(c));
      expect_val("px_border", 32'(c_BORDER));
      pixel(5, 5, 1'b0, c); compare(32'(c));
      expect_val("px_blank", 0);
      pixel(320, 240, 1'b1, c); compare(32'(c));
      expect_val("px_background", 0);
      pixel(100, 100, 1'b0, c); compare(32'(c));
      expect_val("px_sprite_last", 32'(c_GREEN));
      pixel(349, 269, 1'b0, c); compare(32'(c));
      expect_val("px_sprite_past", 0);
      pixel(350, 240, 1'b0, c); compare(32'(c));
      expect_val("px_border_right", 32'(c_BORDER));
      pixel(630, 240, 1'b0, c); compare(32'(c));
      expect_val("px_inside_right", 0);
      pixel(629, 240, 1'b0, c); compare(32'(c));
      expect_val("px_border_bottom", 32'(c_BORDER));
      pixel(320, 470, 1'b0, c); compare(32'(c));

      // Opposing switches cancel
      up_switch = 1'b0; dn_switch = 1'b0;
      expect_val("opp_y", 240);
      expect_val("opp_x", 320);
      repeat (20) do_tick(h);
      compare(32'(dut.o_y));
      compare(32'(dut.o_x));
      up_switch = 1'b1; dn_switch = 1'b1;

      // Plain manual moves
      right_switch = 1'b0;
      expect_val("man_right", 325);
      repeat (5) do_tick(h);
      compare(32'(dut.o_x));
      right_switch = 1'b1; dn_switch = 1'b0;
      expect_val("man_dn", 243);
      repeat (3) do_tick(h);
      compare(32'(dut.o_y));
      dn_switch = 1'b1; left_switch = 1'b0; right_switch = 1'b0;
      expect_val("man_lr_both", 325);
      repeat (3) do_tick(h);
      compare(32'(dut.o_x));
      left_switch = 1'b1; right_switch = 1'b1;

      // Manual clamp at the left limit
      do_reset();
      left_switch = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         expect_val("clamp_hit", 0);
         expect_val("clamp_x", (320 - k > 10) ? 320 - k : 10);
         do_tick(h);
         compare(32'(h));
         compare(32'(dut.o_x));
      end
      left_switch = 1'b1;

      // Bounce from reset; the left switch must be ignored
      do_reset();
      mode_switch = 1'b0;
      left_switch = 1'b0;
      mx = 320; my = 240; mdxn = 1'b0; mdyn = 1'b0; mflash = 0;
      for (int k = 0; k < 300; k++) bounce_tick();
      expect_val("bounce_dx_neg", 1); compare(32'(dut.w_dx_neg));
      expect_val("bounce_dy_neg", 1); compare(32'(dut.w_dy_neg));
      left_switch = 1'b1;

      // Steer to (599,439) manually, then bounce into the corner
      do_reset();
      right_switch = 1'b0; dn_switch = 1'b0;
      repeat (199) do_tick(h);
      dn_switch = 1'b1;
      repeat (80) do_tick(h);
      right_switch = 1'b1;
      expect_val("corner_start_x", 599); compare(32'(dut.o_x));
      expect_val("corner_start_y", 439); compare(32'(dut.o_y));
      mode_switch = 1'b0;
      mx = 599; my = 439; mdxn = 1'b0; mdyn = 1'b0; mflash = 0;
      bounce_tick();
      bounce_tick();
      expect_val("corner_dx_neg", 1); compare(32'(dut.w_dx_neg));
      expect_val("corner_dy_neg", 1); compare(32'(dut.w_dy_neg));
      expect_val("corner_hit_after", 0); compare(32'(hit));
      bounce_tick();
      bounce_tick();

      // Asynchronous reset between ticks while flashing in bounce mode
      repeat (5) @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      expect_val("arst_x", 320);             compare(32'(dut.o_x));
      expect_val("arst_y", 240);             compare(32'(dut.o_y));
      expect_val("arst_state", 32'(MANUAL)); compare(32'(dut.r_state));
      expect_val("arst_hit", 0);             compare(32'(hit));
      expect_val("arst_px", 32'(c_GREEN));
      pixel(320, 240, 1'b0, c); compare(32'(c));
      @(negedge CLK);
      RST = 1'b0;
      mode_switch = 1'b1;

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
